alkmdseq: RTL

//  Parametrised multiply/divide sequencer for the DPM ALU-control path; successor to the ALK MUL/DIV SETUP/LOOP logic.

---
 rtl/alkmdseq.sv | 116 +++++++++++
 1 files changed

// File: rtl/alkmdseq.sv
// Multiply/divide sequencer: SETUP, WIDTH LOOP cycles, optional divide FIXUP, DONE pulse.
// Drives the per-cycle ALKCTL opcode and carry inversion to the ALU bitslices.
module alkmdseq #(
    parameter int unsigned WIDTH = 32,
    localparam int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             qdclk_l,
    input  logic             init_l,
    input  logic             start_h,
    input  logic [1:0]       mode_h,
    input  logic             abort_h,
    input  logic             stall_l,
    input  logic             c_in_h,
    input  logic             q_sout_shr_h,
    output logic [9:0]       alkop_h,
    output logic             carry_invert_h,
    output logic             loop_flag_h,
    output logic             busy_h,
    output logic             done_h,
    output logic [CNT_W-1:0] step_cnt_h
);

    typedef enum logic [2:0] {StIdle, StSetup, StLoop, StFixup, StDone} state_e;

    state_e           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic             tog_q, tog_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tog_sample;

    // mode[1] selects divide; divide-minus uses the inverted carry.
    assign tog_sample = mode_q[1] ? (c_in_h ^ mode_q[0]) : q_sout_shr_h;

    always_ff @(posedge qdclk_l) begin
        if (!init_l) begin
            state_q <= StIdle;
            mode_q  <= 2'b00;
            tog_q   <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            tog_q   <= tog_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        tog_d   = tog_q;
        cnt_d   = cnt_q;
        if (state_q != StIdle && abort_h) begin
            state_d = StIdle;
            tog_d   = 1'b1;
            cnt_d   = '0;
        end else if (stall_l) begin
            unique case (state_q)
                StIdle: begin
                    if (start_h && !abort_h) begin
                        state_d = StSetup;
                        mode_d  = mode_h;
                    end
                end
                StSetup: begin
                    state_d = StLoop;
                    cnt_d   = CNT_W'(WIDTH - 1);
                    tog_d   = tog_sample;
                end
                StLoop: begin
                    tog_d = tog_sample;
                    if (cnt_q == '0) begin
                        state_d = mode_q[1] ? StFixup : StDone;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                StFixup: state_d = StDone;
                StDone: begin
                    state_d = StIdle;
                    tog_d   = 1'b1;
                end
                default: begin
                    state_d = StIdle;
                    tog_d   = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        alkop_h = 10'h000;
        unique case (state_q)
            StSetup: begin
                if (!mode_q[1]) alkop_h = 10'h26B;
                else            alkop_h = mode_q[0] ? 10'h25C : 10'h24C;
            end
            StLoop: begin
                unique case (mode_q)
                    2'b00:   alkop_h = tog_q ? 10'h259 : 10'h25B;
                    2'b01:   alkop_h = tog_q ? 10'h249 : 10'h24B;
                    default: alkop_h = tog_q ? 10'h24C : 10'h25C;
                endcase
            end
            StFixup: alkop_h = tog_q ? 10'h26B : 10'h20A;
            default: alkop_h = 10'h000;
        endcase
    end

    assign carry_invert_h = (alkop_h == 10'h249) || (alkop_h == 10'h24C) || (alkop_h == 10'h20A);
    assign loop_flag_h    = (state_q == StLoop);
    assign busy_h         = (state_q == StSetup) || (state_q == StLoop) || (state_q == StFixup);
    assign done_h         = (state_q == StDone);
    assign step_cnt_h     = (state_q == StLoop) ? cnt_q : '0;

endmodule
